// File: rtl/cpu_ctrl_pkg.sv
// Shared control-decode constants and state type for the EX-stage hazard logic.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] FUNCT_DIV = 6'b011010;

    typedef enum logic [1:0] {
        RUN,
        FLUSH,
        DIV_WAIT
    } ctrl_state_t;

    // Width needed to hold the larger of the two counting ranges, plus headroom.
    function automatic int unsigned ctr_width(input int unsigned a, input int unsigned b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/hazard_flush_ctrl_if.sv
// EX-stage view of the pipeline: decoded instruction fields in, flush/stall/divider controls out.
interface hazard_flush_ctrl_if;

    logic [5:0] OpCode_EX;
    logic [5:0] Funct_EX;
    logic       ALUZero;
    logic       DivDone;

    logic       PCSrc;
    logic       FlushIFID;
    logic       FlushIDEX;
    logic       StallPC;
    logic       StallIFID;
    logic       DivStart;
    logic       DivError;

    // Controller side
    modport master (
        input  OpCode_EX, Funct_EX, ALUZero, DivDone,
        output PCSrc, FlushIFID, FlushIDEX, StallPC, StallIFID, DivStart, DivError
    );

    // Pipeline / divider side
    modport slave (
        output OpCode_EX, Funct_EX, ALUZero, DivDone,
        input  PCSrc, FlushIFID, FlushIDEX, StallPC, StallIFID, DivStart, DivError
    );

endinterface

// File: rtl/hazard_flush_ctrl_cycle_counter.sv
// Shared up/down counter: times the flush window and the divider timeout.
module cycle_counter #(
    parameter int unsigned W = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] term,
    output logic         is_zero,
    output logic         at_term
);

    logic [W-1:0] count;

    // Counter update; clear beats load beats decrement beats increment.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - W'(1);
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    // Terminal compares against the current count.
    always_comb begin
        is_zero = (count == '0);
        at_term = (count == term);
    end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// EX-stage branch flush and multi-cycle divide sequencing for the ID/EX boundary.
module hazard_flush_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [5:0]  DIV_FUNCT    = 6'b011010,
    parameter int unsigned DIV_TIMEOUT  = 40
) (
    input  logic                  Clk,
    input  logic                  Reset,
    hazard_flush_ctrl_if.master   bus
);

    localparam int unsigned   CW         = ctr_width(FLUSH_CYCLES, DIV_TIMEOUT);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES - 1);
    localparam logic [CW-1:0] DIV_TERM   = CW'(DIV_TIMEOUT - 1);

    ctrl_state_t   state;
    logic          taken;
    logic          is_div;
    logic          cnt_clr;
    logic          cnt_load;
    logic          cnt_inc;
    logic          cnt_dec;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_zero;
    logic          cnt_term;

    logic pc_src_q;
    logic flush_ifid_q;
    logic flush_idex_q;
    logic stall_pc_q;
    logic stall_ifid_q;
    logic div_start_q;
    logic div_error_q;

    // Decode of the instruction currently in EX.
    always_comb begin
        taken  = ((bus.OpCode_EX == OP_BEQ) &&  bus.ALUZero) ||
                 ((bus.OpCode_EX == OP_BNE) && !bus.ALUZero);
        is_div = (bus.OpCode_EX == OP_RTYPE) && (bus.Funct_EX == DIV_FUNCT);
    end

    // Counter commands derived from the current state and inputs.
    always_comb begin
        cnt_clr      = 1'b0;
        cnt_load     = 1'b0;
        cnt_inc      = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = '0;
        case (state)
            RUN: begin
                if (taken) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = FLUSH_LOAD;
                end else if (is_div) begin
                    cnt_clr = 1'b1;
                end
            end
            FLUSH: begin
                cnt_dec = !cnt_zero;
            end
            DIV_WAIT: begin
                cnt_inc = !bus.DivDone && !cnt_term;
            end
            default: begin
                cnt_clr = 1'b1;
            end
        endcase
    end

    cycle_counter #(
        .W (CW)
    ) u_cnt (
        .Clk      (Clk),
        .Reset    (Reset),
        .clr      (cnt_clr),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .inc      (cnt_inc),
        .dec      (cnt_dec),
        .term     (DIV_TERM),
        .is_zero  (cnt_zero),
        .at_term  (cnt_term)
    );

    // Control FSM with registered outputs; PCSrc and DivStart are single-cycle pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= RUN;
            pc_src_q     <= 1'b0;
            flush_ifid_q <= 1'b0;
            flush_idex_q <= 1'b0;
            stall_pc_q   <= 1'b0;
            stall_ifid_q <= 1'b0;
            div_start_q  <= 1'b0;
            div_error_q  <= 1'b0;
        end else begin
            pc_src_q    <= 1'b0;
            div_start_q <= 1'b0;
            case (state)
                RUN: begin
                    if (taken) begin
                        pc_src_q     <= 1'b1;
                        flush_ifid_q <= 1'b1;
                        flush_idex_q <= 1'b1;
                        // A one-cycle window needs no FLUSH state: RUN drops the flushes next edge.
                        state        <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                    end else if (is_div) begin
                        div_start_q  <= 1'b1;
                        stall_pc_q   <= 1'b1;
                        stall_ifid_q <= 1'b1;
                        flush_idex_q <= 1'b1;
                        state        <= DIV_WAIT;
                    end else begin
                        flush_ifid_q <= 1'b0;
                        flush_idex_q <= 1'b0;
                        stall_pc_q   <= 1'b0;
                        stall_ifid_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (cnt_zero) begin
                        flush_ifid_q <= 1'b0;
                        flush_idex_q <= 1'b0;
                        state        <= RUN;
                    end
                end
                DIV_WAIT: begin
                    if (bus.DivDone) begin
                        stall_pc_q   <= 1'b0;
                        stall_ifid_q <= 1'b0;
                        flush_idex_q <= 1'b0;
                        state        <= RUN;
                    end else if (cnt_term) begin
                        div_error_q  <= 1'b1;
                        stall_pc_q   <= 1'b0;
                        stall_ifid_q <= 1'b0;
                        flush_idex_q <= 1'b0;
                        state        <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign bus.PCSrc     = pc_src_q;
    assign bus.FlushIFID = flush_ifid_q;
    assign bus.FlushIDEX = flush_idex_q;
    assign bus.StallPC   = stall_pc_q;
    assign bus.StallIFID = stall_ifid_q;
    assign bus.DivStart  = div_start_q;
    assign bus.DivError  = div_error_q;

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl: a behavioural model predicts the outputs after each edge,
// a negedge monitor compares them against the DUT.
module tb_hazard_flush_ctrl;
    import cpu_ctrl_pkg::*;

    localparam int unsigned FC   = 3;
    localparam int unsigned DT   = 40;
    localparam logic [5:0]  DIVF = 6'b011010;

    logic Clk;
    logic Reset;

    hazard_flush_ctrl_if bus ();

    hazard_flush_ctrl #(
        .FLUSH_CYCLES (FC),
        .DIV_FUNCT    (DIVF),
        .DIV_TIMEOUT  (DT)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // {PCSrc, FlushIFID, FlushIDEX, StallPC, StallIFID, DivStart, DivError}
    logic [6:0] exp_q[$];

    // Model state: remaining flush cycles, divide in progress, edge index of the divide start.
    int   flush_left = 0;
    bit   div_active = 1'b0;
    int   div_t0     = 0;
    int   cyc        = 0;
    bit   m_pcsrc    = 1'b0;
    bit   m_dstart   = 1'b0;
    bit   m_err      = 1'b0;

    // Drive one cycle of inputs and queue the outputs expected after the next posedge.
    task automatic step(input bit rst, input logic [5:0] op, input logic [5:0] fn,
                        input bit z, input bit dd);
        bit idle;
        bit tk;
        bit dv;
        @(negedge Clk);
        #1;
        Reset         = rst;
        bus.OpCode_EX = op;
        bus.Funct_EX  = fn;
        bus.ALUZero   = z;
        bus.DivDone   = dd;
        cyc++;
        if (rst) begin
            flush_left = 0;
            div_active = 1'b0;
            m_pcsrc    = 1'b0;
            m_dstart   = 1'b0;
            m_err      = 1'b0;
        end else begin
            idle     = !div_active && !(flush_left > 0 && FC > 1);
            tk       = (op == 6'b000100 && z) || (op == 6'b000101 && !z);
            dv       = (op == 6'b000000) && (fn == DIVF);
            m_pcsrc  = 1'b0;
            m_dstart = 1'b0;
            if (flush_left > 0) flush_left--;
            if (div_active) begin
                if (dd) begin
                    div_active = 1'b0;
                end else if (cyc - div_t0 == int'(DT)) begin
                    div_active = 1'b0;
                    m_err      = 1'b1;
                end
            end
            if (idle) begin
                if (tk) begin
                    flush_left = FC;
                    m_pcsrc    = 1'b1;
                end else if (dv) begin
                    div_active = 1'b1;
                    div_t0     = cyc;
                    m_dstart   = 1'b1;
                end
            end
        end
        exp_q.push_back({m_pcsrc, flush_left > 0, (flush_left > 0) || div_active,
                         div_active, div_active, m_dstart, m_err});
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 6'b001000, 6'($urandom), $urandom_range(0, 1) == 1, 1'b0);
    endtask

    // Monitor: one expected entry per cycle, compared once the DUT has settled.
    always @(negedge Clk) begin
        logic [6:0] e;
        logic [6:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.PCSrc, bus.FlushIFID, bus.FlushIDEX, bus.StallPC, bus.StallIFID,
                 bus.DivStart, bus.DivError};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got=%b expected=%b (PCSrc,FIFID,FIDEX,SPC,SIFID,DStart,DErr)",
                         $time, a, e);
            end
        end
    end

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int sel;
        Reset         = 1'b1;
        bus.OpCode_EX = '0;
        bus.Funct_EX  = '0;
        bus.ALUZero   = 1'b0;
        bus.DivDone   = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) step(1'b1, 6'($urandom), 6'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        @(posedge Clk);
        #1;
        checks++;
        if (dut.state !== RUN) begin
            errors++;
            $display("FAIL reset_state got=%0d expected=%0d", dut.state, RUN);
        end

        // Beq taken, then not taken
        nop(2);
        step(1'b0, OP_BEQ, 6'h00, 1'b1, 1'b0);
        nop(5);
        step(1'b0, OP_BEQ, 6'h00, 1'b0, 1'b0);
        nop(3);

        // Bne taken with Beq inside the flush window
        step(1'b0, OP_BNE, 6'h00, 1'b0, 1'b0);
        step(1'b0, OP_BEQ, 6'h00, 1'b1, 1'b0);
        step(1'b0, OP_BEQ, 6'h00, 1'b1, 1'b0);
        nop(5);

        // Div finished by DivDone, branches during the wait ignored
        step(1'b0, OP_RTYPE, DIVF, 1'b0, 1'b0);
        step(1'b0, OP_BEQ, 6'h00, 1'b1, 1'b0);
        nop(8);
        step(1'b0, OP_ADDI, 6'h00, 1'b0, 1'b1);
        nop(4);

        // Div timing out; DivError sticky until Reset
        step(1'b0, OP_RTYPE, DIVF, 1'b0, 1'b0);
        nop(45);
        step(1'b0, OP_ADDI, 6'h00, 1'b0, 1'b1);
        step(1'b0, OP_BNE, 6'h00, 1'b0, 1'b0);
        nop(4);
        step(1'b1, OP_ADDI, 6'h00, 1'b0, 1'b0);
        nop(2);

        // Reset in the middle of a divide; late DivDone ignored
        step(1'b0, OP_RTYPE, DIVF, 1'b0, 1'b0);
        nop(5);
        step(1'b1, OP_ADDI, 6'h00, 1'b0, 1'b0);
        nop(2);
        step(1'b0, OP_ADDI, 6'h00, 1'b0, 1'b1);
        nop(3);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 9);
            fn  = 6'($urandom);
            case (sel)
                0, 1:    op = OP_BEQ;
                2, 3:    op = OP_BNE;
                4:       begin op = OP_RTYPE; fn = DIVF; end
                5:       op = OP_RTYPE;
                6, 7:    op = OP_ADDI;
                default: op = 6'($urandom);
            endcase
            step($urandom_range(0, 299) == 0, op, fn, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0);
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
        @(posedge Clk);
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
